// File: rtl/mem_pkg.sv
// mem_pkg: op codes, FSM state encoding and op classification helpers for mem_ctrl
package mem_pkg;
  localparam logic [7:0] MEM_FETCH = 8'd1;
  localparam logic [7:0] MEM_LB    = 8'd2;
  localparam logic [7:0] MEM_LH    = 8'd3;
  localparam logic [7:0] MEM_LW    = 8'd4;
  localparam logic [7:0] MEM_LBU   = 8'd5;
  localparam logic [7:0] MEM_LHU   = 8'd6;
  localparam logic [7:0] MEM_SB    = 8'd7;
  localparam logic [7:0] MEM_SH    = 8'd8;
  localparam logic [7:0] MEM_SW    = 8'd9;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_WAIT, ST_RESP} state_t;
  function automatic logic is_load(input logic [7:0] op);
    return op >= MEM_FETCH && op <= MEM_LHU;
  endfunction
  function automatic logic is_store(input logic [7:0] op);
    return op >= MEM_SB && op <= MEM_SW;
  endfunction
  function automatic logic [1:0] access_size(input logic [7:0] op);
    return (op == MEM_LB || op == MEM_LBU || op == MEM_SB) ? 2'd0 :
           (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 2'd1 :
           (op == MEM_FETCH || op == MEM_LW || op == MEM_SW) ? 2'd2 : 2'd3;
  endfunction
endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: picks byte/half at lane from ram word and sign/zero-extends it (q, lane, op in; data out)
module mem_load_align import mem_pkg::*; (
  input  logic [31:0] q,
  input  logic [1:0]  lane,
  input  logic [7:0]  op,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b = q[{lane, 3'b000} +: 8];
    h = lane[1] ? q[31:16] : q[15:0];
    data = (op == MEM_LB)  ? {{24{b[7]}}, b} :
           (op == MEM_LBU) ? {24'b0, b} :
           (op == MEM_LH)  ? {{16{h[15]}}, h} :
           (op == MEM_LHU) ? {16'b0, h} : q;
  end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: one-at-a-time load/store/fetch controller; req_* handshake in, resp_* pulse out, registered ram_* to system_ram
module mem_ctrl import mem_pkg::*; #(
  parameter int          RAM_ADDR_WIDTH = 16,
  parameter int          READ_LATENCY   = 1,
  parameter logic [31:0] ERR_DATA       = 32'h0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_addr,
  input  logic [7:0]                req_op,
  input  logic [31:0]               req_wdata,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic                      ram_wren,
  output logic                      ram_rden,
  output logic [3:0]                ram_byteena,
  output logic [31:0]               ram_data,
  input  logic [31:0]               ram_q
);
  state_t state_q, state_d;
  logic [7:0] op_q, op_d;
  logic [1:0] lane_q, lane_d, cnt_q, cnt_d, sz;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [31:0] ram_data_q, ram_data_d, resp_rdata_q, resp_rdata_d, wd, word, aligned;
  logic [3:0] ram_byteena_q, ram_byteena_d, be;
  logic ram_wren_q, ram_wren_d, ram_rden_q, ram_rden_d, resp_valid_q, resp_valid_d, resp_err_q, resp_err_d, err;
  mem_load_align u_align (.q(ram_q), .lane(lane_q), .op(op_q), .data(aligned));
  always_comb begin
    sz = access_size(req_op);
    word = {2'b00, req_addr[31:2]};
    err = sz == 2'd3 || (sz == 2'd1 && req_addr[0]) || (sz == 2'd2 && req_addr[1:0] != 2'b00) ||
          (word >> RAM_ADDR_WIDTH) != 32'd0;
    be = !is_store(req_op) ? 4'b1111 : sz == 2'd0 ? 4'b0001 << req_addr[1:0] :
         sz == 2'd1 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd = sz == 2'd0 ? {4{req_wdata[7:0]}} : sz == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    state_d = state_q;
    op_d = op_q;
    lane_d = lane_q;
    cnt_d = cnt_q;
    ram_addr_d = ram_addr_q;
    ram_data_d = ram_data_q;
    ram_wren_d = 1'b0;
    ram_rden_d = 1'b0;
    ram_byteena_d = 4'b0000;
    resp_valid_d = 1'b0;
    resp_err_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        op_d = req_op;
        lane_d = req_addr[1:0];
        if (err) begin
          state_d = ST_RESP;
          resp_valid_d = 1'b1;
          resp_err_d = 1'b1;
          resp_rdata_d = ERR_DATA;
        end else begin
          state_d = ST_ACCESS;
          ram_addr_d = req_addr[RAM_ADDR_WIDTH+1:2];
          ram_data_d = is_store(req_op) ? wd : ram_data_q;
          ram_rden_d = is_load(req_op);
          ram_wren_d = is_store(req_op);
          ram_byteena_d = be;
        end
      end
      ST_ACCESS: begin
        state_d = is_store(op_q) ? ST_RESP : ST_WAIT;
        cnt_d = 2'(READ_LATENCY - 1);
        resp_valid_d = is_store(op_q);
        resp_rdata_d = is_store(op_q) ? 32'h0 : resp_rdata_q;
      end
      ST_WAIT: begin
        state_d = cnt_q == 2'd0 ? ST_RESP : ST_WAIT;
        cnt_d = cnt_q == 2'd0 ? cnt_q : cnt_q - 2'd1;
        resp_valid_d = cnt_q == 2'd0;
        resp_rdata_d = cnt_q == 2'd0 ? aligned : resp_rdata_q;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      op_q <= 8'd0;
      lane_q <= 2'd0;
      cnt_q <= 2'd0;
      ram_addr_q <= '0;
      ram_data_q <= 32'd0;
      ram_wren_q <= 1'b0;
      ram_rden_q <= 1'b0;
      ram_byteena_q <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_err_q <= 1'b0;
      resp_rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      lane_q <= lane_d;
      cnt_q <= cnt_d;
      ram_addr_q <= ram_addr_d;
      ram_data_q <= ram_data_d;
      ram_wren_q <= ram_wren_d;
      ram_rden_q <= ram_rden_d;
      ram_byteena_q <= ram_byteena_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end
  assign req_ready = state_q == ST_IDLE;
  assign resp_valid = resp_valid_q;
  assign resp_err = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign ram_wren = ram_wren_q;
  assign ram_rden = ram_rden_q;
  assign ram_byteena = ram_byteena_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed checks of mem_ctrl with READ_LATENCY 1 and 2 against behavioural RAMs
module tb_mem_ctrl;
  import mem_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic a_valid = 1'b0, a_ready, a_rvalid, a_err, a_wren, a_rden;
  logic [31:0] a_addr = '0, a_wdata = '0, a_rdata, a_data, a_q;
  logic [7:0] a_op = '0;
  logic [15:0] a_raddr;
  logic [3:0] a_be;
  logic b_valid = 1'b0, b_ready, b_rvalid, b_err, b_wren, b_rden;
  logic [31:0] b_addr = '0, b_rdata, b_data, b_q, b_pipe;
  logic [7:0] b_op = '0;
  logic [15:0] b_raddr;
  logic [3:0] b_be;
  logic [31:0] mem_a [0:65535];
  logic [31:0] mem_b [0:65535];
  mem_ctrl #(.RAM_ADDR_WIDTH(16), .READ_LATENCY(1), .ERR_DATA(32'h0)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_addr(a_addr), .req_op(a_op),
    .req_wdata(a_wdata), .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_err), .ram_addr(a_raddr),
    .ram_wren(a_wren), .ram_rden(a_rden), .ram_byteena(a_be), .ram_data(a_data), .ram_q(a_q));
  mem_ctrl #(.RAM_ADDR_WIDTH(16), .READ_LATENCY(2), .ERR_DATA(32'h0)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_addr(b_addr), .req_op(b_op),
    .req_wdata(32'h0), .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_err), .ram_addr(b_raddr),
    .ram_wren(b_wren), .ram_rden(b_rden), .ram_byteena(b_be), .ram_data(b_data), .ram_q(b_q));
  always @(posedge clk) begin
    if (a_wren)
      for (int i = 0; i < 4; i++)
        if (a_be[i]) mem_a[a_raddr][8*i +: 8] <= a_data[8*i +: 8];
    if (a_rden) a_q <= mem_a[a_raddr];
  end
  always @(posedge clk) begin
    if (b_rden) b_pipe <= mem_b[b_raddr];
    b_q <= b_pipe;
  end
  int checks = 0, fails = 0, lat;
  logic [31:0] r_data, s_data;
  logic r_err, s_wren, s_rden, seen;
  logic [3:0] s_be;
  logic [15:0] s_addr;
  int acc [$];
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic go(logic [7:0] op, logic [31:0] addr, logic [31:0] wd);
    @(negedge clk);
    for (int i = 0; i < 20 && !a_ready; i++) @(negedge clk);
    a_valid = 1'b1; a_op = op; a_addr = addr; a_wdata = wd;
    @(posedge clk); #1 a_valid = 1'b0;
    lat = 0; s_wren = 0; s_rden = 0; s_be = 0; s_data = 0; s_addr = 0; r_data = 0; r_err = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (a_wren | a_rden) begin
        s_wren |= a_wren; s_rden |= a_rden; s_be = a_be; s_data = a_data; s_addr = a_raddr;
      end
      if (a_rvalid) begin lat = i; r_data = a_rdata; r_err = a_err; end
    end
  endtask
  initial begin
    for (int i = 0; i < 65536; i++) begin mem_a[i] = 32'h0; mem_b[i] = 32'h0; end
    mem_b[0] = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, a_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, a_rvalid}, 32'd0);
    check("rst_enables", {26'b0, a_err, a_wren, a_rden, 3'b0} | {28'b0, a_be}, 32'd0);
    check("rst_ram_addr", {16'b0, a_raddr}, 32'd0);
    check("rst_ram_data", a_data, 32'd0);
    check("rst_resp_rdata", a_rdata, 32'd0);
    @(negedge clk) rst = 1'b0;
    go(MEM_SW, 32'h10, 32'hDEADBEEF);
    check("sw_addr", {16'b0, s_addr}, 32'd4);
    check("sw_be", {28'b0, s_be}, 32'hF);
    check("sw_wren", {30'b0, s_wren, s_rden}, 32'd2);
    check("sw_lat", lat, 2);
    check("sw_err", {31'b0, r_err}, 32'd0);
    go(MEM_LW, 32'h10, 32'h0);
    check("lw_data", r_data, 32'hDEADBEEF);
    check("lw_lat", lat, 3);
    check("lw_rden", {30'b0, s_wren, s_rden}, 32'd1);
    go(MEM_SB, 32'h13, 32'h80);
    check("sb_be", {28'b0, s_be}, 32'h8);
    check("sb_data", s_data, 32'h80808080);
    go(MEM_LB, 32'h13, 32'h0);
    check("lb_data", r_data, 32'hFFFFFF80);
    go(MEM_LBU, 32'h13, 32'h0);
    check("lbu_data", r_data, 32'h00000080);
    go(MEM_SH, 32'h22, 32'h8001);
    check("sh_be", {28'b0, s_be}, 32'hC);
    check("sh_data", s_data, 32'h80018001);
    go(MEM_LH, 32'h22, 32'h0);
    check("lh_data", r_data, 32'hFFFF8001);
    go(MEM_LHU, 32'h22, 32'h0);
    check("lhu_data", r_data, 32'h00008001);
    go(MEM_LW, 32'h11, 32'h0);
    check("lw_mis_err", {31'b0, r_err}, 32'd1);
    check("lw_mis_lat", lat, 1);
    check("lw_mis_en", {30'b0, s_wren, s_rden}, 32'd0);
    check("lw_mis_data", r_data, 32'h0);
    go(MEM_LH, 32'h21, 32'h0);
    check("lh_mis_err", {31'b0, r_err}, 32'd1);
    go(8'd0, 32'h0, 32'h0);
    check("op0_err", {31'b0, r_err}, 32'd1);
    check("op0_en", {30'b0, s_wren, s_rden}, 32'd0);
    go(MEM_SW, 32'h40000, 32'h11111111);
    check("sw_oor_err", {31'b0, r_err}, 32'd1);
    check("sw_oor_nowr", {30'b0, s_wren, s_rden}, 32'd0);
    check("sw_oor_mem0", mem_a[0], 32'h0);
    @(negedge clk);
    for (int i = 0; i < 20 && !a_ready; i++) @(negedge clk);
    a_valid = 1'b1; a_op = MEM_LW; a_addr = 32'h10;
    @(posedge clk); #1 a_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_ready", {31'b0, a_ready}, 32'd1);
    @(negedge clk) rst = 1'b0;
    seen = a_rvalid;
    repeat (6) begin @(posedge clk); #1 seen |= a_rvalid; end
    check("rst_wait_noresp", {31'b0, seen}, 32'd0);
    @(negedge clk);
    a_valid = 1'b1; a_op = MEM_SW; a_addr = 32'h30; a_wdata = 32'h12345678;
    @(posedge clk); #1 a_valid = 1'b0;
    check("rst_st_wren", {31'b0, a_wren}, 32'd1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1 seen |= a_rvalid; end
    check("rst_st_noresp", {31'b0, seen}, 32'd0);
    go(MEM_LW, 32'h30, 32'h0);
    check("rst_st_commit", r_data, 32'h12345678);
    @(negedge clk);
    b_valid = 1'b1; b_op = MEM_FETCH; b_addr = 32'h0;
    @(posedge clk); #1 b_valid = 1'b0;
    lat = 0; r_data = 0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      if (i > 1) begin @(posedge clk); #1; end
      if (b_rvalid) begin lat = i; r_data = b_rdata; end
    end
    check("fetch2_lat", lat, 4);
    check("fetch2_data", r_data, 32'hCAFEF00D);
    @(negedge clk);
    for (int i = 0; i < 20 && !b_ready; i++) @(negedge clk);
    b_valid = 1'b1;
    repeat (16) begin
      if (b_ready) acc.push_back(cyc);
      @(negedge clk);
    end
    b_valid = 1'b0;
    check("b2b_count", acc.size() >= 3, 1);
    if (acc.size() >= 3) begin
      check("b2b_gap1", acc[1] - acc[0], 5);
      check("b2b_gap2", acc[2] - acc[1], 5);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
